// File: rtl/key_interrupt_ctrl_pkg.sv
// Shared receiver definitions for the PS/2 key interrupt controller:
// receiver states, PS/2 frame constants and the break (release) prefix code.
package key_interrupt_ctrl_pkg;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  localparam int          FRAME_DATA_BITS = 8;
  localparam logic        START_BIT       = 1'b0;
  localparam logic        STOP_BIT        = 1'b1;
  localparam logic [7:0]  PS2_BREAK       = 8'hF0;

  // PS/2 uses odd parity across the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/key_interrupt_ctrl_ps2_rx.sv
// PS/2 frame receiver: synchronizes raw ps2_clk/ps2_data, steps one bit per
// falling keyboard-clock edge, and abandons partial frames after a quiet timeout.
module ps2_rx
  import key_interrupt_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic clk_s1, sync_clk, sync_clk_prev;
  logic data_s1, sync_data;
  logic fall;

  rx_state_e     state, state_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          par, par_nxt;
  logic [TW-1:0] to_cnt;
  logic          timeout_hit;

  // Synchronizers idle high so reset never fabricates a falling edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1        <= 1'b1;
      sync_clk      <= 1'b1;
      sync_clk_prev <= 1'b1;
      data_s1       <= 1'b1;
      sync_data     <= 1'b1;
    end else begin
      clk_s1        <= ps2_clk;
      sync_clk      <= clk_s1;
      sync_clk_prev <= sync_clk;
      data_s1       <= ps2_data;
      sync_data     <= data_s1;
    end
  end

  assign fall        = sync_clk_prev & ~sync_clk;
  assign timeout_hit = (state != RX_IDLE) && (to_cnt == TO_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= RX_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      par     <= par_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || fall || state == RX_IDLE) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    par_nxt     = par;
    byte_valid  = 1'b0;
    err         = 1'b0;
    if (fall) begin
      unique case (state)
        RX_IDLE: begin
          if (sync_data == START_BIT) begin
            state_nxt   = RX_DATA;
            bit_cnt_nxt = '0;
          end else begin
            err = 1'b1;
          end
        end
        RX_DATA: begin
          shreg_nxt = {sync_data, shreg[7:1]};
          if (bit_cnt == 3'(FRAME_DATA_BITS - 1)) begin
            state_nxt = RX_PARITY;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
        RX_PARITY: begin
          par_nxt   = sync_data;
          state_nxt = RX_STOP;
        end
        RX_STOP: begin
          if (sync_data == STOP_BIT && odd_parity_ok(shreg, par)) begin
            byte_valid = 1'b1;
          end else begin
            err = 1'b1;
          end
          state_nxt = RX_IDLE;
        end
        default: state_nxt = RX_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_nxt = RX_IDLE;
      err       = 1'b1;
    end
  end

  assign rx_byte = shreg;

endmodule

// File: rtl/key_interrupt_ctrl.sv
// PS/2 keyboard front end: queues received scancodes in a FWFT FIFO and raises
// key_interrupt while data is held. Optional KEY_BREAK_FILTER_EN drops F0 and its follower.
module key_interrupt_ctrl
  import key_interrupt_ctrl_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  input  logic                     key_pop,
  output logic                     key_interrupt,
  output logic [7:0]               key_code,
  output logic [$clog2(DEPTH):0]   key_count,
  output logic                     overflow,
  output logic                     frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    rx_byte;
  logic          byte_valid;
  logic          rx_err;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          empty, full;
  logic          push_req, push_do, pop_do;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .err        (rx_err)
  );

`ifdef KEY_BREAK_FILTER_EN
  logic discard;

  // A break prefix swallows itself and the release code that follows it.
  assign push_req = byte_valid && (rx_byte != PS2_BREAK) && !discard;

  always_ff @(posedge clock) begin
    if (reset) begin
      discard <= 1'b0;
    end else if (byte_valid) begin
      if (discard) begin
        discard <= 1'b0;
      end else if (rx_byte == PS2_BREAK) begin
        discard <= 1'b1;
      end
    end
  end
`else
  assign push_req = byte_valid;
`endif

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_do  = key_pop && !empty;
  assign push_do = push_req && (!full || pop_do);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_do) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_do) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_do, pop_do})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full && !pop_do) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push_do) begin
      mem[wr_ptr] <= rx_byte;
    end
  end

  assign key_interrupt = !empty;
  assign key_code      = empty ? 8'h00 : mem[rd_ptr];
  assign key_count     = count;
  assign frame_err     = rx_err;

endmodule

// File: tb/tb_key_interrupt_ctrl.sv
// Scoreboard bench for key_interrupt_ctrl: expected scancodes and frame errors
// are queued by stimulus and retired by a negedge monitor.
module tb_key_interrupt_ctrl;

  localparam int DEPTH = 8;
  localparam int TO    = 200;
  localparam int HALF  = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_pop = 1'b0;
  logic       key_interrupt;
  logic [7:0] key_code;
  logic [3:0] key_count;
  logic       overflow;
  logic       frame_err;

  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] exp_q[$];
  int         err_q[$];

  key_interrupt_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_pop(key_pop), .key_interrupt(key_interrupt), .key_code(key_code),
    .key_count(key_count), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Monitor: every pop retires one expected scancode, every frame_err one expected error.
  always @(negedge clock) begin
    if (!reset) begin
      if (key_pop) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          if (key_interrupt !== 1'b0) begin
            n_miss++;
            $display("FAIL pop_unexpected: got code %02h int %b, required empty", key_code, key_interrupt);
          end
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (key_code !== e || key_interrupt !== 1'b1) begin
            n_miss++;
            $display("FAIL pop_code: got %02h int %b, required %02h int 1", key_code, key_interrupt, e);
          end
        end
      end
      if (frame_err) begin
        n_vec++;
        if (err_q.size() == 0) begin
          n_miss++;
          $display("FAIL frame_err_unexpected: got pulse, required none");
        end else begin
          void'(err_q.pop_front());
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    key_pop = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic ps2_bit(input logic b, input bit pop_at_fall);
    ps2_data = b;
    repeat (HALF / 2) @(posedge clock);
    #1;
    ps2_clk = 1'b0;
    for (int i = 0; i < HALF; i++) begin
      @(posedge clock); #1;
      key_pop = pop_at_fall && (i == 1);
    end
    ps2_clk = 1'b1;
    repeat (HALF / 2) @(posedge clock);
    #1;
  endtask

  task automatic send_head(input logic [7:0] b, input bit bad_par);
    logic p;
    p = (~^b) ^ bad_par;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit(p, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit pop_at_stop);
    send_head(b, bad_par);
    ps2_bit(1'b1, pop_at_stop);
  endtask

  task automatic do_pop();
    @(posedge clock); #1;
    key_pop = 1'b1;
    @(posedge clock); #1;
    key_pop = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    do_reset();

    @(negedge clock);
    chk("reset_int", key_interrupt, 0);
    chk("reset_code", key_code, 0);
    chk("reset_count", key_count, 0);
    chk("reset_ovf", overflow, 0);
    chk("reset_err", frame_err, 0);

    // Pop on empty is ignored.
    do_pop();
    @(negedge clock);
    chk("empty_pop_count", key_count, 0);

    // Good 1C frame with exact latency check on the stop edge.
    exp_q.push_back(8'h1C);
    @(posedge clock); #1;
    send_head(8'h1C, 1'b0);
    ps2_data = 1'b1;
    repeat (HALF / 2) @(posedge clock);
    #1;
    ps2_clk = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("latency_pre_int", key_interrupt, 0);
    @(posedge clock);
    @(negedge clock);
    chk("latency_int", key_interrupt, 1);
    chk("latency_code", key_code, 8'h1C);
    chk("latency_count", key_count, 1);
    repeat (HALF - 3) @(posedge clock);
    #1;
    ps2_clk = 1'b1;
    repeat (HALF / 2) @(posedge clock);
    #1;
    do_pop();
    @(negedge clock);
    chk("after_pop_int", key_interrupt, 0);
    chk("after_pop_code", key_code, 0);

    // Bad parity and bad start bit each produce one frame_err.
    err_q.push_back(1);
    send_frame(8'h1C, 1'b1, 1'b0);
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("parity_err_seen", err_q.size(), 0);
    chk("parity_count", key_count, 0);
    err_q.push_back(2);
    ps2_bit(1'b1, 1'b0);
    @(negedge clock);
    chk("start_err_seen", err_q.size(), 0);

    // Overflow: nine frames into an eight-entry FIFO.
    for (int i = 1; i <= 9; i++) begin
      b = 8'(i);
      if (i <= 8) exp_q.push_back(b);
      send_frame(b, 1'b0, 1'b0);
    end
    @(negedge clock);
    chk("ovf_count", key_count, 8);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", key_code, 8'h01);
    for (int i = 0; i < 8; i++) do_pop();
    @(negedge clock);
    chk("ovf_drain_count", key_count, 0);
    chk("ovf_sticky", overflow, 1);
    do_reset();
    @(negedge clock);
    chk("ovf_cleared", overflow, 0);

    // Full FIFO with a pop on the same cycle as the ninth push.
    for (int i = 1; i <= 9; i++) exp_q.push_back(8'(i));
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b0);
    send_frame(8'h09, 1'b0, 1'b1);
    @(negedge clock);
    chk("simul_count", key_count, 8);
    chk("simul_ovf", overflow, 0);
    chk("simul_head", key_code, 8'h02);
    for (int i = 0; i < 8; i++) do_pop();
    @(negedge clock);
    chk("simul_drained", key_count, 0);

    // Partial frame then silence: timeout error, then a clean frame.
    err_q.push_back(3);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    repeat (TO + 20) @(posedge clock);
    @(negedge clock);
    chk("timeout_err_seen", err_q.size(), 0);
    chk("timeout_count", key_count, 0);
    exp_q.push_back(8'h2A);
    send_frame(8'h2A, 1'b0, 1'b0);
    @(negedge clock);
    chk("after_timeout_count", key_count, 1);
    do_pop();

    // Reset mid-frame with data queued: nothing survives.
    send_frame(8'h11, 1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    do_reset();
    @(negedge clock);
    chk("midreset_count", key_count, 0);
    chk("midreset_int", key_interrupt, 0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b0, 1'b0);
    @(negedge clock);
    chk("midreset_next", key_code, 8'h55);
    do_pop();

    // Break-code handling.
`ifdef KEY_BREAK_FILTER_EN
    exp_q.push_back(8'h32);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'h32, 1'b0, 1'b0);
    @(negedge clock);
    chk("break_count", key_count, 1);
    do_pop();
`else
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h1C);
    exp_q.push_back(8'h32);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'h32, 1'b0, 1'b0);
    @(negedge clock);
    chk("break_count", key_count, 3);
    for (int i = 0; i < 3; i++) do_pop();
`endif

    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("codes_all_retired", exp_q.size(), 0);
    chk("errs_all_retired", err_q.size(), 0);
    chk("final_count", key_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/key_interrupt_ctrl.md
Name: key_interrupt_ctrl

Overview:
- PS/2 keyboard front end that drives the processor's key_interrupt input and supplies scancodes to it.
- Samples raw ps2_clk/ps2_data, deframes 11-bit PS/2 frames and queues good bytes in a first-word-fall-through FIFO.
- key_interrupt is a level request while the FIFO holds data; the processor reads key_code and pops via key_pop.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
TIMEOUT_CYCLES, 50000, clock cycles with no ps2_clk falling edge before a partial frame is abandoned.

Ports:
clock  in  1  system clock, all logic on posedge.
reset  in  1  synchronous, active-high; clears all state.
ps2_clk  in  1  raw keyboard clock, asynchronous.
ps2_data  in  1  raw keyboard data, asynchronous.
key_pop  in  1  one-cycle pop of the FIFO head.
key_interrupt  out  1  high while FIFO not empty.
key_code  out  8  FIFO head; 8'h00 when empty.
key_count  out  $clog2(DEPTH)+1  current occupancy.
overflow  out  1  sticky; a good byte was dropped because the FIFO was full.
frame_err  out  1  one-cycle pulse on a parity, start-bit, stop-bit or timeout error.

Behaviour:
- Reset: FIFO empty; key_interrupt=0, key_code=0, key_count=0, overflow=0, frame_err=0; receiver in IDLE; synchronizers cleared to 1.
- Synchronizers: two flops on each of ps2_clk and ps2_data, then a third flop on clk for edge detection.
- A falling edge is sync_clk_prev=1 and sync_clk=0. Data is sampled only on that cycle.
- Receiver FSM, advancing one step per falling edge:
  - IDLE: data=0 -> DATA with bit_cnt=0; data=1 -> pulse frame_err, stay IDLE.
  - DATA: shift bits in LSB first; after the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: if data=1 and odd parity over data+parity holds, the byte is good and is pushed this cycle; otherwise pulse frame_err. Always return to IDLE.
- Timeout counter:
  - Resets on every falling edge; increments in any non-IDLE state.
  - On reaching TIMEOUT_CYCLES-1: return to IDLE, discard the partial byte, pulse frame_err.
- Latency: a good byte is visible on key_code, with key_interrupt high, on the clock after the STOP falling edge is detected.
- FIFO:
  - Head read is combinational from registered storage; pointers are DEPTH-wrapping with an occupancy counter.
  - Pop when empty: ignored, no state change.
  - Push when full without a same-cycle pop: byte dropped, overflow set.
  - Push and pop in the same cycle when full: both succeed, count unchanged.
  - Push and pop in the same cycle when empty: push only; pop ignored.
- overflow clears only on reset.
- Reset mid-frame: the receiver returns to IDLE and the FIFO is emptied; no partial byte survives.

Optional Feature:
- Macro: KEY_BREAK_FILTER_EN.
- Defined: a good byte 8'hF0 is not queued and arms a one-byte discard; the next good byte is also not queued (release codes suppressed). The discard flag clears on reset. A frame error does not clear it.
- Undefined: every good byte is queued, including F0.

Decomposition:
- Shared include key_defs.vh holds:
  - receiver state encodings (IDLE, DATA, PARITY, STOP);
  - frame constants: 8 data bits, start=0, stop=1;
  - PS2_BREAK = 8'hF0.
- Sub-module ps2_rx: synchronizers, edge detect, FSM, timeout. Outputs byte[7:0], byte_valid pulse and err pulse.
- The FIFO and interrupt logic stay in key_interrupt_ctrl.

Test Plan:
- Good frame 8'h1C (start 0, bits LSB first, parity 0, stop 1) -> one cycle after the stop edge: key_interrupt=1, key_code=8'h1C, key_count=1; key_pop -> key_interrupt=0, key_code=0.
- Frame 8'h1C with parity bit 1 -> frame_err pulses once, key_count stays 0.
- Frames 8'h01..8'h09 with DEPTH=8 and no pops -> key_count=8, overflow=1, key_code=8'h01; pop order is 01..08.
- With FIFO full, key_pop asserted on the same cycle as the 9th push -> key_count stays 8, overflow stays 0, tail=8'h09.
- Start bit plus 3 data bits, then silence for TIMEOUT_CYCLES -> frame_err pulse, FSM back in IDLE; the next full frame 8'h2A is received correctly.
- Bytes F0,1C,32: macro defined -> only 8'h32 is queued; macro undefined -> key_count=3.
